// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU memory bus arbiter.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_BUSY,
    DATA_BUSY
  } arbiter_state_t;

  typedef enum logic {
    FETCH,
    DATA
  } requester_t;

  // Wide enough for any supported data width; users take the low DATA_WIDTH/8 bits.
  localparam int unsigned                MAX_BYTE_LANES = 64;
  localparam logic [MAX_BYTE_LANES-1:0] BYTEENABLE_ALL = '1;

endpackage

// File: rtl/bus_request_register.sv
// Holds the bus-side address, strobes and write payload of the granted transaction.
module bus_request_register #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      clear,
  input  logic [ADDRESS_WIDTH-1:0]  load_address,
  input  logic                      load_read,
  input  logic                      load_write,
  input  logic [DATA_WIDTH-1:0]     load_writedata,
  input  logic [DATA_WIDTH/8-1:0]   load_byteenable,
  output logic [ADDRESS_WIDTH-1:0]  address,
  output logic                      read,
  output logic                      write,
  output logic [DATA_WIDTH-1:0]     writedata,
  output logic [DATA_WIDTH/8-1:0]   byteenable
);

  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic                     read_q, read_d;
  logic                     write_q, write_d;
  logic [DATA_WIDTH-1:0]    writedata_q, writedata_d;
  logic [DATA_WIDTH/8-1:0]  byteenable_q, byteenable_d;

  // Clear only withdraws the strobes; the payload lingers harmlessly until the next load.
  always_comb begin
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    if (load) begin
      address_d    = load_address;
      read_d       = load_read;
      write_d      = load_write;
      writedata_d  = load_writedata;
      byteenable_d = load_byteenable;
    end else if (clear) begin
      read_d  = 1'b0;
      write_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
    end else begin
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
    end
  end

  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

endmodule

// File: rtl/memory_bus_arbiter.sv
// Arbitrates the single Avalon-style master port between instruction fetch and load/store.
module memory_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_request,
  input  logic [ADDRESS_WIDTH-1:0]  fetch_address,
  output logic [DATA_WIDTH-1:0]     fetch_readdata,
  output logic                      fetch_valid,
  input  logic                      data_read,
  input  logic                      data_write,
  input  logic [ADDRESS_WIDTH-1:0]  data_address,
  input  logic [DATA_WIDTH-1:0]     data_writedata,
  input  logic [DATA_WIDTH/8-1:0]   data_byteenable,
  output logic [DATA_WIDTH-1:0]     data_readdata,
  output logic                      data_valid,
  output logic                      stall_fetch_memory,
  output logic                      stall_data_memory,
  output logic [ADDRESS_WIDTH-1:0]  address,
  output logic                      read,
  output logic                      write,
  output logic [DATA_WIDTH-1:0]     writedata,
  output logic [DATA_WIDTH/8-1:0]   byteenable,
  input  logic [DATA_WIDTH-1:0]     readdata,
  input  logic                      waitrequest
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  arbiter_state_t state_q, state_d;
  requester_t     last_grant_q, last_grant_d;

  logic                     data_req_c;
  logic                     load_c;
  logic                     clear_c;
  logic [ADDRESS_WIDTH-1:0] ld_address_c;
  logic                     ld_read_c;
  logic                     ld_write_c;
  logic [DATA_WIDTH-1:0]    ld_writedata_c;
  logic [BE_WIDTH-1:0]      ld_byteenable_c;

  assign data_req_c = data_read | data_write;

  // Completion is only reported to a requester that is still asking for it.
  assign fetch_valid        = (state_q == FETCH_BUSY) && !waitrequest && fetch_request;
  assign data_valid         = (state_q == DATA_BUSY) && !waitrequest && data_req_c;
  assign fetch_readdata     = readdata;
  assign data_readdata      = readdata;
  assign stall_fetch_memory = fetch_request && !fetch_valid;
  assign stall_data_memory  = data_req_c && !data_valid;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    load_c          = 1'b0;
    clear_c         = 1'b0;
    ld_address_c    = '0;
    ld_read_c       = 1'b0;
    ld_write_c      = 1'b0;
    ld_writedata_c  = '0;
    ld_byteenable_c = '0;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (data_req_c && (!fetch_request || last_grant_q == FETCH)) begin
          load_c          = 1'b1;
          ld_address_c    = data_address;
          ld_read_c       = data_read && !data_write;
          ld_write_c      = data_write;
          ld_writedata_c  = data_writedata;
          ld_byteenable_c = data_byteenable;
          state_d         = DATA_BUSY;
        end else if (fetch_request) begin
          load_c          = 1'b1;
          ld_address_c    = fetch_address;
          ld_read_c       = 1'b1;
          ld_byteenable_c = BYTEENABLE_ALL[BE_WIDTH-1:0];
          state_d         = FETCH_BUSY;
        end
      end
      FETCH_BUSY: begin
        if (!waitrequest) begin
          clear_c      = 1'b1;
          last_grant_d = FETCH;
          state_d      = IDLE;
        end
      end
      DATA_BUSY: begin
        if (!waitrequest) begin
          clear_c      = 1'b1;
          last_grant_d = DATA;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= FETCH;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  bus_request_register #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_bus_request_register (
    .clk             (clk),
    .reset           (reset),
    .load            (load_c),
    .clear           (clear_c),
    .load_address    (ld_address_c),
    .load_read       (ld_read_c),
    .load_write      (ld_write_c),
    .load_writedata  (ld_writedata_c),
    .load_byteenable (ld_byteenable_c),
    .address         (address),
    .read            (read),
    .write           (write),
    .writedata       (writedata),
    .byteenable      (byteenable)
  );

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_memory_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_request = 1'b0;
  logic [31:0] fetch_address = '0;
  logic [31:0] fetch_readdata;
  logic        fetch_valid;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_address = '0;
  logic [31:0] data_writedata = '0;
  logic [3:0]  data_byteenable = '0;
  logic [31:0] data_readdata;
  logic        data_valid;
  logic        stall_fetch_memory;
  logic        stall_data_memory;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = '0;
  logic        waitrequest = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_bus_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .fetch_request      (fetch_request),
    .fetch_address      (fetch_address),
    .fetch_readdata     (fetch_readdata),
    .fetch_valid        (fetch_valid),
    .data_read          (data_read),
    .data_write         (data_write),
    .data_address       (data_address),
    .data_writedata     (data_writedata),
    .data_byteenable    (data_byteenable),
    .data_readdata      (data_readdata),
    .data_valid         (data_valid),
    .stall_fetch_memory (stall_fetch_memory),
    .stall_data_memory  (stall_data_memory),
    .address            (address),
    .read               (read),
    .write              (write),
    .writedata          (writedata),
    .byteenable         (byteenable),
    .readdata           (readdata),
    .waitrequest        (waitrequest)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding bus transaction record and who won last.
  bit          m_active = 1'b0;
  bit          m_owner_data = 1'b0;
  bit          m_last_data = 1'b0;
  logic [31:0] m_addr = '0;
  bit          m_rd = 1'b0;
  bit          m_wr = 1'b0;
  logic [31:0] m_wd = '0;
  logic [3:0]  m_be = '0;

  always @(negedge clk) begin : compare
    bit dreq;
    dreq = data_read | data_write;
    if (reset) begin
      chk("rst_read", 64'(read), 64'd0);
      chk("rst_write", 64'(write), 64'd0);
      chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
      chk("rst_data_valid", 64'(data_valid), 64'd0);
      m_active = 1'b0;
      m_last_data = 1'b0;
    end else begin
      chk("m_read", 64'(read), 64'(m_active && m_rd));
      chk("m_write", 64'(write), 64'(m_active && m_wr));
      chk("m_fetch_valid", 64'(fetch_valid),
          64'(m_active && !m_owner_data && !waitrequest && fetch_request));
      chk("m_data_valid", 64'(data_valid),
          64'(m_active && m_owner_data && !waitrequest && dreq));
      chk("m_stall_fetch", 64'(stall_fetch_memory), 64'(fetch_request && !fetch_valid));
      chk("m_stall_data", 64'(stall_data_memory), 64'(dreq && !data_valid));
      chk("m_fetch_rdata", 64'(fetch_readdata), 64'(readdata));
      chk("m_data_rdata", 64'(data_readdata), 64'(readdata));
      if (m_active) begin
        chk("m_address", 64'(address), 64'(m_addr));
        chk("m_byteenable", 64'(byteenable), 64'(m_be));
        if (m_wr) chk("m_writedata", 64'(writedata), 64'(m_wd));
      end
      // advance the model by the clock edge that follows
      if (m_active) begin
        if (!waitrequest) begin
          m_active = 1'b0;
          m_last_data = m_owner_data;
        end
      end else if (dreq && (!fetch_request || !m_last_data)) begin
        m_active = 1'b1; m_owner_data = 1'b1; m_addr = data_address;
        m_wr = data_write; m_rd = !data_write; m_wd = data_writedata; m_be = data_byteenable;
      end else if (fetch_request) begin
        m_active = 1'b1; m_owner_data = 1'b0; m_addr = fetch_address;
        m_wr = 1'b0; m_rd = 1'b1; m_be = 4'hF;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic idle_all();
    fetch_request = 1'b0; data_read = 1'b0; data_write = 1'b0; waitrequest = 1'b0;
  endtask

  initial begin
    cyc(); cyc();
    reset = 1'b0;
    mid();
    chk("reset_read", 64'(read), 64'd0);
    chk("reset_address", 64'(address), 64'd0);

    // fetch only, zero wait
    cyc();
    fetch_request = 1'b1; fetch_address = 32'hBFC0_0000; readdata = 32'h2402_0005;
    mid();
    chk("f1_stall_c0", 64'(stall_fetch_memory), 64'd1);
    chk("f1_read_c0", 64'(read), 64'd0);
    cyc(); mid();
    chk("f1_read_c1", 64'(read), 64'd1);
    chk("f1_addr_c1", 64'(address), 64'hBFC0_0000);
    chk("f1_be_c1", 64'(byteenable), 64'hF);
    chk("f1_valid_c1", 64'(fetch_valid), 64'd1);
    chk("f1_rdata_c1", 64'(fetch_readdata), 64'h2402_0005);
    chk("f1_stall_c1", 64'(stall_fetch_memory), 64'd0);
    cyc(); idle_all(); mid();
    chk("f1_read_c2", 64'(read), 64'd0);

    // simultaneous requests alternate starting with data
    do_reset();
    fetch_request = 1'b1; fetch_address = 32'h100;
    data_read = 1'b1; data_address = 32'h2000;
    mid();
    chk("rr_read_c0", 64'(read), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); mid();
      chk("rr_grant_addr", 64'(address), (k % 2 == 0) ? 64'h2000 : 64'h100);
      chk("rr_grant_dv", 64'(data_valid), (k % 2 == 0) ? 64'd1 : 64'd0);
      chk("rr_grant_fv", 64'(fetch_valid), (k % 2 == 0) ? 64'd0 : 64'd1);
      cyc(); mid();
      chk("rr_idle_read", 64'(read), 64'd0);
    end
    cyc(); idle_all(); cyc(); cyc();

    // store held under waitrequest
    data_write = 1'b1; data_address = 32'h2004; data_writedata = 32'hDEAD_BEEF;
    data_byteenable = 4'b0011; waitrequest = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc(); mid();
      chk("st_write", 64'(write), 64'd1);
      chk("st_read", 64'(read), 64'd0);
      chk("st_addr", 64'(address), 64'h2004);
      chk("st_wdata", 64'(writedata), 64'hDEAD_BEEF);
      chk("st_be", 64'(byteenable), 64'h3);
      chk("st_dv_wait", 64'(data_valid), 64'd0);
    end
    cyc(); waitrequest = 1'b0; mid();
    chk("st_dv", 64'(data_valid), 64'd1);
    chk("st_read_c4", 64'(read), 64'd0);
    cyc(); idle_all(); mid();
    chk("st_write_done", 64'(write), 64'd0);

    // fetch abandoned under waitrequest
    cyc();
    fetch_request = 1'b1; fetch_address = 32'h40; waitrequest = 1'b1;
    cyc(); mid();
    chk("ab_read_c1", 64'(read), 64'd1);
    cyc(); fetch_request = 1'b0; mid();
    chk("ab_read_c2", 64'(read), 64'd1);
    cyc(); waitrequest = 1'b0; mid();
    chk("ab_read_c3", 64'(read), 64'd1);
    chk("ab_fv_c3", 64'(fetch_valid), 64'd0);
    cyc(); mid();
    chk("ab_read_c4", 64'(read), 64'd0);

    // reset during a data transaction
    cyc();
    fetch_request = 1'b1; fetch_address = 32'h80;
    data_read = 1'b1; data_address = 32'h3000; waitrequest = 1'b1;
    cyc(); mid();
    chk("rm_addr_c1", 64'(address), 64'h3000);
    chk("rm_read_c1", 64'(read), 64'd1);
    cyc();
    #2 reset = 1'b1;
    #1;
    chk("rm_read_async", 64'(read), 64'd0);
    chk("rm_write_async", 64'(write), 64'd0);
    waitrequest = 1'b0;
    mid();
    chk("rm_dv_in_reset", 64'(data_valid), 64'd0);
    cyc(); reset = 1'b0; mid();
    chk("rm_idle_read", 64'(read), 64'd0);
    chk("rm_idle_dv", 64'(data_valid), 64'd0);
    cyc(); mid();
    chk("rm_tie_data", 64'(address), 64'h3000);
    chk("rm_tie_dv", 64'(data_valid), 64'd1);
    cyc(); idle_all(); cyc();

    // read and write together become a write
    data_read = 1'b1; data_write = 1'b1; data_address = 32'h44;
    data_writedata = 32'h1122_3344; data_byteenable = 4'hF;
    cyc(); mid();
    chk("rw_write", 64'(write), 64'd1);
    chk("rw_read", 64'(read), 64'd0);
    chk("rw_dv", 64'(data_valid), 64'd1);
    cyc(); idle_all(); cyc();

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      fetch_request = ($urandom_range(0, 3) != 0);
      fetch_address = $urandom & 32'hFFFF_FFFC;
      data_read = $urandom_range(0, 1) == 1;
      data_write = $urandom_range(0, 3) == 0;
      data_address = $urandom;
      data_writedata = $urandom;
      data_byteenable = 4'($urandom);
      waitrequest = ($urandom_range(0, 2) == 0);
      readdata = $urandom;
      cyc();
    end
    reset = 1'b0;
    idle_all();
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares the CPU's single Avalon-style memory master port between the fetch stage (instruction reads) and the memory stage (loads/stores).
- Owns bus sequencing: grant FSM, round-robin tie-break, and holding bus signals stable under waitrequest.
- Generates per-stage stall requests that the hazard unit ORs into its fetch/decode stall and execute-flush logic.

Parameters:
ADDRESS_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of read/write data buses; byteenable is DATA_WIDTH/8

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
fetch_request  input  1  fetch stage wants an instruction word
fetch_address  input  ADDRESS_WIDTH  instruction address, word aligned
fetch_readdata  output  DATA_WIDTH  instruction word, valid with fetch_valid
fetch_valid  output  1  fetch transaction completes this cycle
data_read  input  1  memory stage load request
data_write  input  1  memory stage store request
data_address  input  ADDRESS_WIDTH  load/store address
data_writedata  input  DATA_WIDTH  store data
data_byteenable  input  DATA_WIDTH/8  store/load lane enables
data_readdata  output  DATA_WIDTH  load data, valid with data_valid
data_valid  output  1  data transaction completes this cycle
stall_fetch_memory  output  1  fetch stage must hold
stall_data_memory  output  1  memory stage must hold
address  output  ADDRESS_WIDTH  bus address
read  output  1  bus read strobe
write  output  1  bus write strobe
writedata  output  DATA_WIDTH  bus write data
byteenable  output  DATA_WIDTH/8  bus lane enables
readdata  input  DATA_WIDTH  bus read data, valid when read && !waitrequest
waitrequest  input  1  slave not ready; master holds all bus outputs

Behaviour:
- Clocking: one clock (clk). Reset is asynchronous and active-high, port name reset.
- FSM states: IDLE, FETCH_BUSY, DATA_BUSY. Reset → IDLE, last_grant=FETCH, read=write=0, address/writedata/byteenable=0.
- data_req = data_read | data_write. If data_read and data_write are both high, the request is a write; the read is ignored.
- IDLE:
  - Neither request: stay IDLE; read=write=0.
  - Only one request: register that requester's address, strobe and data into the bus registers; go to the matching *_BUSY state.
  - Both requests: grant the requester that was not last_grant. After reset this is data.
  - Fetch grants drive byteenable all-ones, read=1, write=0.
- *_BUSY:
  - Bus outputs come from registers and are held constant while waitrequest=1.
  - On waitrequest=0 the transaction completes: deassert strobes next edge, update last_grant, return to IDLE.
  - Minimum latency is 2 cycles from request to valid; no back-to-back issue from BUSY.
- Completion signals:
  - fetch_valid = (state==FETCH_BUSY) && !waitrequest && fetch_request.
  - data_valid = (state==DATA_BUSY) && !waitrequest && data_req.
  - Both are combinational, one cycle wide.
  - *_readdata passes readdata through combinationally. Writes also pulse data_valid.
- Stalls: stall_fetch_memory = fetch_request && !fetch_valid; stall_data_memory = data_req && !data_valid.
- Abandon: if the granted requester drops its request while BUSY (flush), the bus transaction still runs to completion. The strobe is never withdrawn under waitrequest. No valid pulse is issued and the result is discarded.
- A requester still asserting its request after its valid pulse is treated as a new transaction.
- Reset mid-transaction: strobes drop immediately (asynchronous), FSM returns to IDLE, and no valid pulse is issued.
- waitrequest in IDLE is ignored.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - the enum arbiter_state_t {IDLE, FETCH_BUSY, DATA_BUSY};
  - the enum requester_t {FETCH, DATA};
  - the constant BYTEENABLE_ALL.
- One natural sub-module, bus_request_register: it captures address/read/write/writedata/byteenable on a load pulse and holds them. This keeps the FSM separate from the datapath registers.

Test Plan:
- Fetch only, addr 0xBFC00000, waitrequest=0 on the first bus cycle, readdata 0x24020005 → read=1 at cycle 1, fetch_valid=1 with fetch_readdata=0x24020005 at cycle 1, stall_fetch_memory=1 at cycle 0 only.
- Simultaneous fetch 0x100 and load 0x2000 after reset → data granted first, data_valid pulses, then IDLE, then fetch granted. With both held continuously, grants alternate D,F,D,F.
- Store 0x2004, writedata 0xDEADBEEF, byteenable 0b0011, waitrequest high for 3 cycles → address/writedata/byteenable/write stable all 3 cycles, data_valid on the 4th bus cycle, read=0 throughout.
- Fetch granted, fetch_request dropped during waitrequest → read held until waitrequest=0, fetch_valid never asserts, FSM returns to IDLE.
- reset asserted mid DATA_BUSY with waitrequest=1 → read/write drop asynchronously, FSM in IDLE, no valid pulse, next tie goes to data.
- data_read and data_write both high → write=1, read=0 on the bus.
